global_pht_predictor: RTL and testbench
=======================================

# global_pht_predictor

Global (gshare) direction predictor that produces `global_predicton_taken` for the tournament selector, alongside the local predictor. Indexes a table of 2-bit saturating counters with PC bits XOR the 12-bit global history. Keeps a small in-order FIFO of in-flight lookups so each resolved outcome trains the exact entry that produced its prediction. Also reports mispredicts for the choice predictor.

## Interface
- `GHR_WIDTH`, 12, history width; table has 2^GHR_WIDTH counters
- `PC_WIDTH`, 32, PC width
- `FIFO_DEPTH`, 4, max in-flight lookups (power of two)
- `CTR_INIT`, 2'b01, counter value written during init (weakly not-taken)

Ports:
- `clock`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-low
- `lookup_valid`  in  1  prediction request
- `lookup_pc`  in  PC_WIDTH  branch PC
- `global_history`  in  GHR_WIDTH  current GHR value
- `lookup_ready`  out  1  request can be accepted this cycle
- `pred_valid`  out  1  prediction valid (one cycle after accept)
- `pred_taken`  out  1  predicted direction (`global_predicton_taken`)
- `resolve_valid`  in  1  oldest in-flight branch resolved
- `resolve_taken`  in  1  actual outcome
- `flush`  in  1  discard all in-flight lookups
- `upd_valid`  out  1  a resolve was applied last cycle
- `upd_mispredict`  out  1  that resolve disagreed with its prediction
- `outstanding`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- `underflow_err`  out  1  sticky: resolve arrived with FIFO empty

## Operation
- Index = `lookup_pc[GHR_WIDTH+1:2] ^ global_history`.
- States: INIT, RUN.
  - Reset low → INIT with `init_ptr`=0; FIFO cleared; all outputs 0.
  - INIT: write CTR_INIT to entry `init_ptr` each cycle and increment it. `lookup_ready`=0. Resolves are ignored and do not set `underflow_err`. After writing entry 2^GHR_WIDTH−1, go to RUN.
  - RUN: normal operation. Reset low from any state returns to INIT.
- `lookup_ready` = RUN && !full && !flush.
- Accept = `lookup_valid && lookup_ready`. On accept:
  - read counter[idx];
  - push {idx, counter[1]} onto the FIFO;
  - next cycle: `pred_valid`=1 and `pred_taken`=counter[1].
- Resolve is applied when `resolve_valid` && RUN && !empty && !flush. On apply:
  - pop the head entry;
  - counter[head.idx] saturates: taken → min(c+1, 3); not-taken → max(c−1, 0);
  - next cycle: `upd_valid`=1 and `upd_mispredict` = (`resolve_taken` != head.pred).
- Resolve in RUN with the FIFO empty and no flush: no counter change, `upd_valid` stays 0, `underflow_err` set to 1 until reset.
- Forwarding: if an accepted lookup and an applied resolve hit the same index in the same cycle, the lookup uses the updated counter value.
- Push and pop in the same cycle: occupancy unchanged. When full, no push is accepted even if a pop happens that cycle.
- Flush: next cycle occupancy is 0. It overrides a same-cycle lookup (not accepted, `pred_valid` 0 next cycle) and a same-cycle resolve (dropped, no update, no error). Counters are untouched.
- FIFO read and write pointers wrap modulo FIFO_DEPTH. Occupancy is tracked separately so that full and empty are distinct.

## Timing
- Reset values: `lookup_ready`, `pred_valid`, `pred_taken`, `upd_valid`, `upd_mispredict`, `outstanding`, `underflow_err` all 0.
- INIT lasts exactly 2^GHR_WIDTH cycles (4096 at default). `lookup_ready` first rises in cycle 4096 after reset deasserts.
- Lookup to prediction: 1 cycle, registered. Throughput: 1 lookup per cycle.
- Resolve to counter update: the write lands at the next edge, so a lookup in the following cycle sees the new value.
- Resolve to `upd_*`: 1 cycle, registered.
- `pred_valid` and `upd_valid` are single-cycle pulses per event.
- `outstanding` is registered and reflects the push/pop/flush of the previous cycle.

## Test plan
- Reset, then wait: `lookup_ready`=0 for 4096 cycles, then 1. First lookup (pc=0x1000, ghr=0) → `pred_valid`=1, `pred_taken`=0 one cycle later.
- Training: pc=0x40, ghr=0x010. Do lookup then resolve taken, twice. Third lookup → `pred_taken`=1. First resolve gives `upd_mispredict`=1; second resolve gives `upd_mispredict`=0.
- Saturation: 5 taken resolves on one index leave the counter at 3; one not-taken resolve → next prediction still 1; a second not-taken → prediction 0.
- FIFO limits: 4 lookups with no resolve → `outstanding`=4 and `lookup_ready`=0. A 5th lookup is not accepted (no `pred_valid`). Resolve with lookup in the same cycle while full → pop only. Resolve when empty → `underflow_err`=1, no `upd_valid`.
- Forwarding and flush: with a counter at 1, resolve taken and look up the same index in the same cycle → `pred_taken`=1. Flush with 3 outstanding plus a same-cycle lookup and resolve → `outstanding`=0, no `pred_valid`, no `upd_valid`, counters unchanged.
- Reset mid-run with 2 outstanding → all outputs 0, FIFO empty, INIT repeats. A previously trained index predicts 0 after INIT.

Source files
------------

// File: rtl/global_pht_predictor.sv
// Gshare direction predictor: 2-bit counters indexed by PC ^ GHR, with an
// in-order FIFO of in-flight lookups so each resolve trains its own entry.
module global_pht_predictor #(
  parameter int unsigned GHR_WIDTH  = 12,
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [1:0]  CTR_INIT   = 2'b01
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          lookup_valid,
  input  logic [PC_WIDTH-1:0]           lookup_pc,
  input  logic [GHR_WIDTH-1:0]          global_history,
  output logic                          lookup_ready,
  output logic                          pred_valid,
  output logic                          pred_taken,
  input  logic                          resolve_valid,
  input  logic                          resolve_taken,
  input  logic                          flush,
  output logic                          upd_valid,
  output logic                          upd_mispredict,
  output logic [$clog2(FIFO_DEPTH):0]   outstanding,
  output logic                          underflow_err
);

  localparam int unsigned ENTRIES = 1 << GHR_WIDTH;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e               state_q, state_d;
  logic [GHR_WIDTH-1:0] init_ptr_q, init_ptr_d;

  logic [1:0]           pht_q [ENTRIES];
  logic [GHR_WIDTH-1:0] fifo_idx_q  [FIFO_DEPTH];
  logic                 fifo_pred_q [FIFO_DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 pred_valid_q, pred_taken_q;
  logic                 upd_valid_q, upd_mis_q;
  logic                 underflow_q, underflow_d;

  logic                 run, full, empty;
  logic                 accept, apply, underflow_evt;
  logic [GHR_WIDTH-1:0] lk_idx, head_idx;
  logic                 head_pred;
  logic [1:0]           old_ctr, new_ctr, lk_ctr;
  logic                 pht_we;
  logic [GHR_WIDTH-1:0] pht_widx;
  logic [1:0]           pht_wdata;
  logic                 unused_pc;

  assign unused_pc = ^{lookup_pc[PC_WIDTH-1:GHR_WIDTH+2], lookup_pc[1:0]};

  assign run   = (state_q == ST_RUN);
  assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);

  assign lookup_ready  = run && !full && !flush;
  assign accept        = lookup_valid && lookup_ready;
  assign apply         = resolve_valid && run && !empty && !flush;
  assign underflow_evt = resolve_valid && run && empty && !flush;

  assign lk_idx    = lookup_pc[GHR_WIDTH+1:2] ^ global_history;
  assign head_idx  = fifo_idx_q[rd_ptr_q];
  assign head_pred = fifo_pred_q[rd_ptr_q];
  assign old_ctr   = pht_q[head_idx];

  always_comb begin
    new_ctr = old_ctr;
    if (resolve_taken) begin
      if (old_ctr != 2'b11) new_ctr = old_ctr + 2'd1;
    end else begin
      if (old_ctr != 2'b00) new_ctr = old_ctr - 2'd1;
    end
  end

  // Same-cycle resolve to the looked-up index forwards the trained value
  assign lk_ctr = (apply && head_idx == lk_idx) ? new_ctr : pht_q[lk_idx];

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    unique case (state_q)
      ST_INIT: begin
        init_ptr_d = init_ptr_q + GHR_WIDTH'(1);
        if (init_ptr_q == '1) state_d = ST_RUN;
      end
      ST_RUN: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    underflow_d = underflow_q || underflow_evt;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (apply)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({accept, apply})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_comb begin
    pht_we    = 1'b0;
    pht_widx  = head_idx;
    pht_wdata = new_ctr;
    if (reset) begin
      if (state_q == ST_INIT) begin
        pht_we    = 1'b1;
        pht_widx  = init_ptr_q;
        pht_wdata = CTR_INIT;
      end else if (apply) begin
        pht_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_INIT;
      init_ptr_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      upd_valid_q  <= 1'b0;
      upd_mis_q    <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      pred_valid_q <= accept;
      pred_taken_q <= accept && lk_ctr[1];
      upd_valid_q  <= apply;
      upd_mis_q    <= apply && (resolve_taken != head_pred);
      underflow_q  <= underflow_d;
    end
  end

  // Storage arrays carry no reset; INIT rewrites every counter
  always_ff @(posedge clock) begin
    if (pht_we) pht_q[pht_widx] <= pht_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset && accept) begin
      fifo_idx_q[wr_ptr_q]  <= lk_idx;
      fifo_pred_q[wr_ptr_q] <= lk_ctr[1];
    end
  end

  assign pred_valid     = pred_valid_q;
  assign pred_taken     = pred_taken_q;
  assign upd_valid      = upd_valid_q;
  assign upd_mispredict = upd_mis_q;
  assign outstanding    = cnt_q;
  assign underflow_err  = underflow_q;

endmodule

// File: tb/tb_global_pht_predictor.sv
// Directed bench for global_pht_predictor: init timing, training,
// saturation, FIFO limits, forwarding, flush and mid-run reset.
module tb_global_pht_predictor;

  logic        clock;
  logic        reset;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic [11:0] global_history;
  logic        lookup_ready;
  logic        pred_valid;
  logic        pred_taken;
  logic        resolve_valid;
  logic        resolve_taken;
  logic        flush;
  logic        upd_valid;
  logic        upd_mispredict;
  logic [2:0]  outstanding;
  logic        underflow_err;

  int checks;
  int failures;
  int n;

  global_pht_predictor dut (
    .clock          (clock),
    .reset          (reset),
    .lookup_valid   (lookup_valid),
    .lookup_pc      (lookup_pc),
    .global_history (global_history),
    .lookup_ready   (lookup_ready),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .resolve_valid  (resolve_valid),
    .resolve_taken  (resolve_taken),
    .flush          (flush),
    .upd_valid      (upd_valid),
    .upd_mispredict (upd_mispredict),
    .outstanding    (outstanding),
    .underflow_err  (underflow_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    lookup_valid   = 1'b0;
    lookup_pc      = '0;
    global_history = '0;
    resolve_valid  = 1'b0;
    resolve_taken  = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_ready"}, lookup_ready, 0);
    chk({tag, "_pvalid"}, pred_valid, 0);
    chk({tag, "_ptaken"}, pred_taken, 0);
    chk({tag, "_uvalid"}, upd_valid, 0);
    chk({tag, "_umis"}, upd_mispredict, 0);
    chk({tag, "_outst"}, outstanding, 0);
    chk({tag, "_uflow"}, underflow_err, 0);
  endtask

  task automatic wait_init(output int cyc);
    cyc = 0;
    while (cyc < 5000) begin
      tick();
      cyc++;
      if (lookup_ready) break;
    end
  endtask

  task automatic lk(input string tag, input logic [31:0] pc,
                    input logic [11:0] ghr, input logic exp_pred);
    lookup_valid   = 1'b1;
    lookup_pc      = pc;
    global_history = ghr;
    tick();
    clr();
    chk({tag, "_pvalid"}, pred_valid, 1);
    chk({tag, "_ptaken"}, pred_taken, exp_pred);
  endtask

  task automatic rs(input string tag, input logic taken,
                    input logic exp_mis);
    resolve_valid = 1'b1;
    resolve_taken = taken;
    tick();
    clr();
    chk({tag, "_uvalid"}, upd_valid, 1);
    chk({tag, "_umis"}, upd_mispredict, exp_mis);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr();
    reset = 1'b0;
    repeat (3) tick();
    all_zero("rst");

    reset = 1'b1;
    chk("init_ready0", lookup_ready, 0);
    wait_init(n);
    chk("init_cycles", n, 4096);

    // idx 0x400, counter 01
    lk("first", 32'h1000, 12'h000, 1'b0);
    chk("first_outst", outstanding, 1);
    rs("first_rs", 1'b0, 1'b0);
    chk("pulse_pvalid", pred_valid, 0);
    chk("first_outst0", outstanding, 0);

    // idx 0: 01 -> 10 -> 11
    lk("tr1", 32'h40, 12'h010, 1'b0);
    rs("tr1_rs", 1'b1, 1'b1);
    lk("tr2", 32'h40, 12'h010, 1'b1);
    rs("tr2_rs", 1'b1, 1'b0);
    lk("tr3", 32'h40, 12'h010, 1'b1);
    rs("tr3_rs", 1'b1, 1'b0);
    lk("sat4", 32'h40, 12'h010, 1'b1);
    rs("sat4_rs", 1'b1, 1'b0);
    lk("sat5", 32'h40, 12'h010, 1'b1);
    rs("sat5_rs", 1'b1, 1'b0);
    lk("dn1", 32'h40, 12'h010, 1'b1);
    rs("dn1_rs", 1'b0, 1'b1);
    lk("dn2", 32'h40, 12'h010, 1'b1);
    rs("dn2_rs", 1'b0, 1'b1);
    lk("dn3", 32'h40, 12'h010, 1'b0);
    rs("dn3_rs", 1'b0, 1'b0);

    // idx 0x40..0x43 fill the FIFO
    lk("f0", 32'h100, 12'h000, 1'b0);
    lk("f1", 32'h104, 12'h000, 1'b0);
    lk("f2", 32'h108, 12'h000, 1'b0);
    lk("f3", 32'h10C, 12'h000, 1'b0);
    chk("full_outst", outstanding, 4);
    chk("full_ready", lookup_ready, 0);
    lookup_valid = 1'b1;
    lookup_pc    = 32'h110;
    tick();
    clr();
    chk("f5_pvalid", pred_valid, 0);
    chk("f5_outst", outstanding, 4);

    lookup_valid  = 1'b1;
    lookup_pc     = 32'h110;
    resolve_valid = 1'b1;
    resolve_taken = 1'b1;
    tick();
    clr();
    chk("fpop_pvalid", pred_valid, 0);
    chk("fpop_uvalid", upd_valid, 1);
    chk("fpop_umis", upd_mispredict, 1);
    chk("fpop_outst", outstanding, 3);
    rs("d1", 1'b0, 1'b0);
    rs("d2", 1'b0, 1'b0);
    rs("d3", 1'b0, 1'b0);
    chk("drain_outst", outstanding, 0);
    lk("chk40", 32'h100, 12'h000, 1'b1);
    rs("chk40_rs", 1'b1, 1'b0);

    resolve_valid = 1'b1;
    resolve_taken = 1'b1;
    tick();
    clr();
    chk("uf_uvalid", upd_valid, 0);
    chk("uf_err", underflow_err, 1);
    chk("uf_outst", outstanding, 0);

    // idx 0x44 at 01; resolve and lookup same index together
    lk("fw0", 32'h110, 12'h000, 1'b0);
    lookup_valid  = 1'b1;
    lookup_pc     = 32'h110;
    resolve_valid = 1'b1;
    resolve_taken = 1'b1;
    tick();
    clr();
    chk("fw_pvalid", pred_valid, 1);
    chk("fw_ptaken", pred_taken, 1);
    chk("fw_umis", upd_mispredict, 1);
    chk("fw_outst", outstanding, 1);
    rs("fw_rs", 1'b1, 1'b0);
    chk("uf_sticky", underflow_err, 1);

    lk("fl0", 32'h114, 12'h000, 1'b0);
    lk("fl1", 32'h118, 12'h000, 1'b0);
    lk("fl2", 32'h11C, 12'h000, 1'b0);
    chk("fl_outst3", outstanding, 3);
    flush         = 1'b1;
    lookup_valid  = 1'b1;
    lookup_pc     = 32'h120;
    resolve_valid = 1'b1;
    resolve_taken = 1'b1;
    #1;
    chk("fl_ready", lookup_ready, 0);
    tick();
    clr();
    chk("fl_outst", outstanding, 0);
    chk("fl_pvalid", pred_valid, 0);
    chk("fl_uvalid", upd_valid, 0);
    lk("fl_keep", 32'h114, 12'h000, 1'b0);
    rs("fl_keep_rs", 1'b1, 1'b1);
    chk("fl_outst_end", outstanding, 0);

    // idx 0x44 trained to 3, two in flight, then reset
    lk("pre0", 32'h110, 12'h000, 1'b1);
    lk("pre1", 32'h110, 12'h000, 1'b1);
    chk("pre_outst", outstanding, 2);
    reset = 1'b0;
    tick();
    all_zero("rst2");
    reset         = 1'b1;
    resolve_valid = 1'b1;
    resolve_taken = 1'b1;
    wait_init(n);
    clr();
    chk("init2_cycles", n, 4096);
    chk("init2_uflow", underflow_err, 0);
    chk("init2_outst", outstanding, 0);
    lk("post", 32'h110, 12'h000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
